alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_op_decode.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
// Covers opcodes, alu_ctrl encodings, FSM states and the response counter width.
package alu_pkg;

  localparam int OP_COUNT_W = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_NOR  = 3'd4,
    OP_NAND = 3'd5,
    OP_SLT  = 3'd6,
    OP_ILL  = 3'd7
  } alu_op_e;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode to alu_ctrl translation.
// Opcode 7 has no ALU encoding and is reported through 'illegal'.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_AND;
    illegal = 1'b0;
    case (op)
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_NOR:  ctrl = CTRL_NOR;
      OP_NAND: ctrl = CTRL_NAND;
      OP_SLT:  ctrl = CTRL_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 32-bit ALU: one request in flight, registered response.
// Optional compare-hint sideband enabled by defining ALU_ISSUE_CMP_EN.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
`ifdef ALU_ISSUE_CMP_EN
  input  logic [2:0]            in_cmp,
  output logic [2:0]            alu_bonus,
`endif
  output logic                  alu_rst_n,
  output logic [31:0]           alu_src1,
  output logic [31:0]           alu_src2,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_cout,
  input  logic                  alu_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic                  out_zero,
  output logic                  out_cout,
  output logic                  out_overflow,
  output logic                  out_err,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_e     state;
  logic       ready_en;
  logic       is_arith;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       accept;
  logic       resp_hs;

  alu_op_decode u_dec (
    .op      (in_op),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign alu_rst_n = rst_n;

  // ready_en keeps in_ready low through reset until the first edge after release
  assign in_ready = ready_en && ((state == IDLE) || ((state == RESP) && out_ready));
  assign accept   = in_valid && in_ready;
  assign resp_hs  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      is_arith     <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_cout     <= 1'b0;
      out_overflow <= 1'b0;
      out_err      <= 1'b0;
      op_count     <= '0;
`ifdef ALU_ISSUE_CMP_EN
      alu_bonus    <= '0;
`endif
    end else begin
      ready_en <= 1'b1;
      if (resp_hs && (op_count != {OP_COUNT_W{1'b1}}))
        op_count <= op_count + 1'b1;

      case (state)
        IDLE, RESP: begin
          if ((state == RESP) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (accept) begin
            if (dec_illegal) begin
              // illegal opcodes bypass the ALU and respond on the next edge
              out_result   <= '0;
              out_zero     <= 1'b0;
              out_cout     <= 1'b0;
              out_overflow <= 1'b0;
              out_err      <= 1'b1;
              out_valid    <= 1'b1;
              state        <= RESP;
            end else begin
              alu_src1  <= in_a;
              alu_src2  <= in_b;
              alu_ctrl  <= dec_ctrl;
              is_arith  <= (in_op == OP_ADD) || (in_op == OP_SUB);
`ifdef ALU_ISSUE_CMP_EN
              alu_bonus <= (in_op == OP_SLT) ? in_cmp : 3'b000;
`endif
              out_valid <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          out_result   <= alu_result;
          out_zero     <= alu_zero;
          out_cout     <= alu_cout && is_arith;
          out_overflow <= alu_overflow;
          out_err      <= 1'b0;
          out_valid    <= 1'b1;
          state        <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
